ram_frame_row_2p_clr: RTL and testbench
=======================================

Name: ram_frame_row_2p_clr

Overview:
- Parametrised two-port frame-row line buffer for the intra path. It is the next generation of the fixed 32x480 row RAM.
- Generalised width and depth, per-lane write masking, defined collision rules, optional output register and read-valid flags.
- A built-in clear engine zeroes the whole array after reset or on request.
- Both ports share one clock. Sits between intra prediction and reconstruction to hold the above-row neighbour pixels across CTU rows.

Parameters:
- WORD_WIDTH, 32, data word width in bits; must be a multiple of LANE_WIDTH.
- ADDR_WIDTH, 9, address width.
- DEPTH, 480, number of valid words; DEPTH <= 2**ADDR_WIDTH.
- LANE_WIDTH, 8, write-mask granularity in bits.
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).

Ports:
- clk  in  1  clock for both ports
- rst_n  in  1  asynchronous reset, active low
- clr_i  in  1  one-cycle pulse; starts a full-array clear
- busy_o  out  1  high while a clear is in progress
- cena_i  in  1  port A chip enable, low active
- oena_i  in  1  port A output enable, low active
- wena_i  in  1  port A write enable, low active
- wmaska_i  in  WORD_WIDTH/LANE_WIDTH  port A lane write mask, low active (0 = write lane)
- addra_i  in  ADDR_WIDTH  port A address
- dataa_i  in  WORD_WIDTH  port A write data
- dataa_o  out  WORD_WIDTH  port A read data
- vlda_o  out  1  port A read data valid
- cenb_i, oenb_i, wenb_i, wmaskb_i, addrb_i, datab_i, datab_o, vldb_o: same as port A, for port B

Behaviour:
- Reset (rst_n low): data registers = 0, vld = 0, busy_o = 1, clear FSM enters CLEAR with clear address = 0. Array contents are undefined until the clear completes.
- FSM IDLE: clr_i = 1 -> CLEAR, address = 0, busy_o = 1 from the next cycle.
- FSM CLEAR: writes 0 to the current address each cycle and increments it. After writing DEPTH-1 -> IDLE; busy_o falls the cycle after the last write. A full clear takes DEPTH cycles.
  - clr_i is ignored while in CLEAR.
  - Asserting reset mid-clear restarts the clear from address 0.
- During CLEAR, all port accesses are dropped: no writes, no read updates, vld = 0, data registers hold.
- Write (IDLE, cen = 0, wen = 0, addr < DEPTH): lanes whose mask bit is 0 take data_i; other lanes keep their contents. Data is visible to reads from the next cycle.
- Read (IDLE, cen = 0, wen = 1): data register loads mem[addr] at the clock edge.
  - OUT_REG = 0: data is presented 1 cycle after the request; vld pulses high in that same cycle.
  - OUT_REG = 1: data is presented 2 cycles after the request; vld follows the same timing.
  - Data registers hold when no read is issued; vld = 1 only for accepted reads.
- Address >= DEPTH: writes are ignored; reads return 0 with vld = 1.
- Collisions, same cycle, same address:
  - A-write and B-write: port A wins on lanes both enable; lanes written by only one port take that port's data.
  - Read on one port, write on the other: read returns the old data (read-before-write).
- Output enable: data_o = 0 when oen = 1 (no tristate), otherwise the data register. oen does not affect vld or the register contents.

Decomposition:
- Shared include ram_defs.vh: lane count NUM_LANES = WORD_WIDTH/LANE_WIDTH, FSM state encodings (IDLE = 1'b0, CLEAR = 1'b1), helper localparam macros.
- Sub-module ram_2p_core: the storage array with per-lane masked write on two ports, A-priority merge, and registered read. It contains no reset, so it maps to a foundry macro.
- The top level holds the clear FSM, the mux that selects clear writes over port writes, range checks, the OUT_REG stage and the vld logic.

Test Plan:
- Reset release, DEPTH = 480 -> busy_o high for exactly 480 cycles. Afterwards, reading addresses 0, 239 and 479 returns 0 with vld one cycle later.
- A writes 0xDEADBEEF to address 5 with wmaska = 4'b0000; B then writes 0x11223344 to address 5 with wmaskb = 4'b1010 (lanes 0 and 2 written). Reading address 5 -> 0xDE22BE44.
- Same cycle, A writes 0xAAAAAAAA and B writes 0x55555555 to address 10, both full masks -> reading address 10 returns 0xAAAAAAAA.
- Address 20 holds 0x1; A writes 0x2 to address 20 while B reads address 20 in the same cycle -> datab_o = 0x1. A read the next cycle returns 0x2.
- Pulse clr_i mid-traffic -> busy_o asserts, a write to address 7 during the clear is dropped, vld stays 0; after 480 cycles address 7 reads 0. A reset at clear cycle 100 restarts the full 480-cycle sweep.
- OUT_REG = 1: a read of address 3 (holding 0x12345678) returns data and vld 2 cycles later. A read of address 500 returns 0 with vld = 1. oena = 1 forces dataa_o = 0 while vlda_o still pulses.

Source files
------------

// File: rtl/ram_frame_row_2p_clr_pkg.sv
// Shared definitions for the two-port frame-row line buffer:
// clear-FSM state encodings and the lane-count helper.
package ram_frame_row_2p_clr_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    function automatic int unsigned num_lanes(input int unsigned word_w,
                                              input int unsigned lane_w);
        return word_w / lane_w;
    endfunction

endpackage

// File: rtl/ram_frame_row_2p_clr_core.sv
// Reset-free two-port storage array with per-lane masked writes and a registered read.
// Port A overrides port B on lanes both ports write in the same cycle.
module ram_2p_core
    import ram_frame_row_2p_clr_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DEPTH      = 480,
    parameter int unsigned LANE_WIDTH = 8
) (
    input  logic                                         clk,
    input  logic [num_lanes(WORD_WIDTH, LANE_WIDTH)-1:0] wea_i,
    input  logic                                         rea_i,
    input  logic [ADDR_WIDTH-1:0]                        addra_i,
    input  logic [WORD_WIDTH-1:0]                        dataa_i,
    output logic [WORD_WIDTH-1:0]                        qa_o,
    input  logic [num_lanes(WORD_WIDTH, LANE_WIDTH)-1:0] web_i,
    input  logic                                         reb_i,
    input  logic [ADDR_WIDTH-1:0]                        addrb_i,
    input  logic [WORD_WIDTH-1:0]                        datab_i,
    output logic [WORD_WIDTH-1:0]                        qb_o
);

    localparam int unsigned NUM_LANES = num_lanes(WORD_WIDTH, LANE_WIDTH);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] qa_q;
    logic [WORD_WIDTH-1:0] qb_q;

    // B lanes are scheduled first so a later A assignment to the same lane wins.
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (web_i[l]) begin
                mem_q[addrb_i][l*LANE_WIDTH +: LANE_WIDTH] <= datab_i[l*LANE_WIDTH +: LANE_WIDTH];
            end
            if (wea_i[l]) begin
                mem_q[addra_i][l*LANE_WIDTH +: LANE_WIDTH] <= dataa_i[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        if (rea_i) begin
            qa_q <= mem_q[addra_i];
        end
        if (reb_i) begin
            qb_q <= mem_q[addrb_i];
        end
    end

    assign qa_o = qa_q;
    assign qb_o = qb_q;

endmodule

// File: rtl/ram_frame_row_2p_clr.sv
// Two-port frame-row line buffer: clear engine, range checks, optional output
// register and read-valid flags around a reset-free storage core.
module ram_frame_row_2p_clr
    import ram_frame_row_2p_clr_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DEPTH      = 480,
    parameter int unsigned LANE_WIDTH = 8,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr_i,
    output logic                                 busy_o,
    input  logic                                 cena_i,
    input  logic                                 oena_i,
    input  logic                                 wena_i,
    input  logic [WORD_WIDTH/LANE_WIDTH-1:0]     wmaska_i,
    input  logic [ADDR_WIDTH-1:0]                addra_i,
    input  logic [WORD_WIDTH-1:0]                dataa_i,
    output logic [WORD_WIDTH-1:0]                dataa_o,
    output logic                                 vlda_o,
    input  logic                                 cenb_i,
    input  logic                                 oenb_i,
    input  logic                                 wenb_i,
    input  logic [WORD_WIDTH/LANE_WIDTH-1:0]     wmaskb_i,
    input  logic [ADDR_WIDTH-1:0]                addrb_i,
    input  logic [WORD_WIDTH-1:0]                datab_i,
    output logic [WORD_WIDTH-1:0]                datab_o,
    output logic                                 vldb_o
);

    localparam int unsigned NUM_LANES = num_lanes(WORD_WIDTH, LANE_WIDTH);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clearing;
    logic                  in_a, in_b, rd_a, rd_b, wr_a, wr_b;
    logic                  vld1a_q, vld1b_q, rdoka_q, rdokb_q;
    logic [NUM_LANES-1:0]  core_wea, core_web;
    logic [ADDR_WIDTH-1:0] core_addra;
    logic [WORD_WIDTH-1:0] core_dataa, core_qa, core_qb;
    logic [WORD_WIDTH-1:0] data1a, data1b, dataa_s, datab_s;
    logic                  vlda_s, vldb_s;

    assign clearing = (state_q == ST_CLEAR);
    assign busy_o   = clearing;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (clearing) begin
            if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = ST_IDLE;
            end else begin
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            end
        end else if (clr_i) begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
        end
    end

    assign in_a = 32'(addra_i) < DEPTH;
    assign in_b = 32'(addrb_i) < DEPTH;
    assign rd_a = !clearing && !cena_i && wena_i;
    assign rd_b = !clearing && !cenb_i && wenb_i;
    assign wr_a = !clearing && !cena_i && !wena_i && in_a;
    assign wr_b = !clearing && !cenb_i && !wenb_i && in_b;

    // Clear sweeps ride on port A; port B is already blocked while clearing.
    assign core_wea   = clearing ? '1 : (wr_a ? ~wmaska_i : '0);
    assign core_addra = clearing ? clr_addr_q : addra_i;
    assign core_dataa = clearing ? '0 : dataa_i;
    assign core_web   = wr_b ? ~wmaskb_i : '0;

    ram_2p_core #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_core (
        .clk     (clk),
        .wea_i   (core_wea),
        .rea_i   (rd_a && in_a),
        .addra_i (core_addra),
        .dataa_i (core_dataa),
        .qa_o    (core_qa),
        .web_i   (core_web),
        .reb_i   (rd_b && in_b),
        .addrb_i (addrb_i),
        .datab_i (datab_i),
        .qb_o    (core_qb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            vld1a_q    <= 1'b0;
            vld1b_q    <= 1'b0;
            rdoka_q    <= 1'b0;
            rdokb_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            vld1a_q    <= rd_a;
            vld1b_q    <= rd_b;
            if (rd_a) rdoka_q <= in_a;
            if (rd_b) rdokb_q <= in_b;
        end
    end

    // The core read register has no reset; the rdok flags supply the zero after
    // reset and after an out-of-range read, and hold along with the core register.
    assign data1a = rdoka_q ? core_qa : '0;
    assign data1b = rdokb_q ? core_qb : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WORD_WIDTH-1:0] d2a_q, d2b_q;
            logic                  v2a_q, v2b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2a_q <= '0;
                    d2b_q <= '0;
                    v2a_q <= 1'b0;
                    v2b_q <= 1'b0;
                end else begin
                    v2a_q <= vld1a_q;
                    v2b_q <= vld1b_q;
                    if (vld1a_q) d2a_q <= data1a;
                    if (vld1b_q) d2b_q <= data1b;
                end
            end

            assign dataa_s = d2a_q;
            assign datab_s = d2b_q;
            assign vlda_s  = v2a_q;
            assign vldb_s  = v2b_q;
        end else begin : g_no_out_reg
            assign dataa_s = data1a;
            assign datab_s = data1b;
            assign vlda_s  = vld1a_q;
            assign vldb_s  = vld1b_q;
        end
    endgenerate

    assign dataa_o = oena_i ? '0 : dataa_s;
    assign datab_o = oenb_i ? '0 : datab_s;
    assign vlda_o  = vlda_s;
    assign vldb_o  = vldb_s;

endmodule

// File: tb/tb_ram_frame_row_2p_clr.sv
// Bench for ram_frame_row_2p_clr: drives identical traffic into an OUT_REG=0 and an
// OUT_REG=1 instance and compares both against an array-based reference model.
module tb_ram_frame_row_2p_clr;

    localparam int DEPTH = 480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        cena, oena, wena, cenb, oenb, wenb;
    logic [3:0]  wmaska, wmaskb;
    logic [8:0]  addra, addrb;
    logic [31:0] dataa, datab;

    logic        busy0, va0, vb0, busy1, va1, vb1;
    logic [31:0] da0, db0, da1, db1;

    logic [31:0] mem [DEPTH];
    int          clear_left;
    logic [31:0] m_d0a, m_d0b, m_d1a, m_d1b;
    logic        m_v0a, m_v0b, m_v1a, m_v1b;

    int npass = 0;
    int nfail = 0;
    int ntotal = 0;
    int n;

    always #5 clk = ~clk;

    ram_frame_row_2p_clr dut0 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy0),
        .cena_i(cena), .oena_i(oena), .wena_i(wena), .wmaska_i(wmaska),
        .addra_i(addra), .dataa_i(dataa), .dataa_o(da0), .vlda_o(va0),
        .cenb_i(cenb), .oenb_i(oenb), .wenb_i(wenb), .wmaskb_i(wmaskb),
        .addrb_i(addrb), .datab_i(datab), .datab_o(db0), .vldb_o(vb0)
    );

    ram_frame_row_2p_clr #(.OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy1),
        .cena_i(cena), .oena_i(oena), .wena_i(wena), .wmaska_i(wmaska),
        .addra_i(addra), .dataa_i(dataa), .dataa_o(da1), .vlda_o(va1),
        .cenb_i(cenb), .oenb_i(oenb), .wenb_i(wenb), .wmaskb_i(wmaskb),
        .addrb_i(addrb), .datab_i(datab), .datab_o(db1), .vldb_o(vb1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        clear_left = DEPTH;
        m_d0a = '0; m_d0b = '0; m_d1a = '0; m_d1b = '0;
        m_v0a = 0;  m_v0b = 0;  m_v1a = 0;  m_v1b = 0;
    endtask

    // One clock edge of the reference behaviour: clear sweep, or reads (old data) then writes.
    task automatic model_edge();
        if (!rst_n) return;
        m_d1a = m_d0a; m_v1a = m_v0a;
        m_d1b = m_d0b; m_v1b = m_v0b;
        if (clear_left > 0) begin
            mem[DEPTH - clear_left] = '0;
            clear_left--;
            m_v0a = 0;
            m_v0b = 0;
        end else begin
            m_v0a = !cena && wena;
            m_v0b = !cenb && wenb;
            if (m_v0a) m_d0a = (int'(addra) < DEPTH) ? mem[addra] : 32'h0;
            if (m_v0b) m_d0b = (int'(addrb) < DEPTH) ? mem[addrb] : 32'h0;
            for (int l = 0; l < 4; l++) begin
                if (!cenb && !wenb && int'(addrb) < DEPTH && !wmaskb[l])
                    mem[addrb][l*8 +: 8] = datab[l*8 +: 8];
            end
            for (int l = 0; l < 4; l++) begin
                if (!cena && !wena && int'(addra) < DEPTH && !wmaska[l])
                    mem[addra][l*8 +: 8] = dataa[l*8 +: 8];
            end
            if (clr) clear_left = DEPTH;
        end
    endtask

    task automatic check_all();
        chk("busy0", 32'(busy0), 32'(clear_left > 0));
        chk("busy1", 32'(busy1), 32'(clear_left > 0));
        chk("d0.dataa", da0, oena ? 32'h0 : m_d0a);
        chk("d0.vlda", 32'(va0), 32'(m_v0a));
        chk("d0.datab", db0, oenb ? 32'h0 : m_d0b);
        chk("d0.vldb", 32'(vb0), 32'(m_v0b));
        chk("d1.dataa", da1, oena ? 32'h0 : m_d1a);
        chk("d1.vlda", 32'(va1), 32'(m_v1a));
        chk("d1.datab", db1, oenb ? 32'h0 : m_d1b);
        chk("d1.vldb", 32'(vb1), 32'(m_v1b));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_idle();
        clr = 0;
        cena = 1; oena = 0; wena = 1; wmaska = '1; addra = '0; dataa = '0;
        cenb = 1; oenb = 0; wenb = 1; wmaskb = '1; addrb = '0; datab = '0;
    endtask

    task automatic wra(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        cena = 0; wena = 0; addra = a; dataa = d; wmaska = m;
    endtask

    task automatic wrb(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        cenb = 0; wenb = 0; addrb = a; datab = d; wmaskb = m;
    endtask

    task automatic rda(input logic [8:0] a);
        cena = 0; wena = 1; addra = a;
    endtask

    task automatic rdb(input logic [8:0] a);
        cenb = 0; wenb = 1; addrb = a;
    endtask

    task automatic wait_clear(input string tag, input int exp_cycles);
        n = 0;
        while (busy0 === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        set_idle();
        #1 rst_n = 0;
        model_reset();
        #1 check_all();
        tick();
        tick();
        rst_n = 1;

        // Post-reset clear sweep length.
        wait_clear("reset_clear_len", DEPTH);

        // Cleared contents at the ends and middle.
        set_idle(); rda(0);   rdb(239); tick();
        chk("clr_read0_vld", 32'(va0), 32'd1);
        set_idle(); rda(479); tick();
        chk("clr_read479", da0, 32'h0);
        set_idle(); tick();

        // Lane-masked writes from both ports.
        set_idle(); wra(5, 32'hDEADBEEF, 4'b0000); tick();
        set_idle(); wrb(5, 32'h11223344, 4'b1010); tick();
        set_idle(); rda(5); tick();
        chk("lane_merge", da0, 32'hDE22BE44);
        set_idle(); tick();
        chk("lane_merge_or1", da1, 32'hDE22BE44);

        // Same-cycle double write: port A wins.
        set_idle(); wra(10, 32'hAAAAAAAA, 4'b0000); wrb(10, 32'h55555555, 4'b0000); tick();
        set_idle(); rdb(10); tick();
        chk("ww_collision", db0, 32'hAAAAAAAA);

        // Read-before-write across ports.
        set_idle(); wra(20, 32'h1, 4'b0000); tick();
        set_idle(); wra(20, 32'h2, 4'b0000); rdb(20); tick();
        chk("rbw_old", db0, 32'h1);
        set_idle(); rdb(20); tick();
        chk("rbw_new", db0, 32'h2);

        // Clear request mid-traffic drops accesses and zeroes the array.
        set_idle(); wra(7, 32'hCAFEF00D, 4'b0000); tick();
        set_idle(); clr = 1; rdb(20); tick();
        set_idle(); wra(7, 32'hFFFFFFFF, 4'b0000); rdb(7); tick();
        chk("clr_busy", 32'(busy0), 32'd1);
        chk("clr_drop_vld", 32'(vb0), 32'd0);
        set_idle();
        wait_clear("req_clear_len", DEPTH - 1);
        set_idle(); rda(7); tick();
        chk("clr_addr7", da0, 32'h0);

        // Reset at clear cycle 100 restarts the full sweep.
        set_idle(); clr = 1; tick();
        set_idle();
        repeat (100) tick();
        rst_n = 0;
        model_reset();
        #1 check_all();
        tick();
        rst_n = 1;
        wait_clear("restart_clear_len", DEPTH);

        // Output register latency, out-of-range read, output enable.
        set_idle(); wra(3, 32'h12345678, 4'b0000); tick();
        set_idle(); rda(3); tick();
        chk("or1_lat1_vld", 32'(va1), 32'd0);
        set_idle(); tick();
        chk("or1_data", da1, 32'h12345678);
        chk("or1_vld", 32'(va1), 32'd1);
        set_idle(); rda(500); tick();
        set_idle(); tick();
        chk("oor_data", da1, 32'h0);
        chk("oor_vld", 32'(va1), 32'd1);
        set_idle(); rda(3); oena = 1; tick();
        chk("oen_data", da0, 32'h0);
        chk("oen_vld", 32'(va0), 32'd1);
        set_idle(); oena = 1; tick();
        chk("oen_vld_or1", 32'(va1), 32'd1);

        // Randomised two-port traffic over a small window plus out-of-range addresses.
        for (int i = 0; i < 400; i++) begin
            cena   = ($urandom_range(0, 3) == 0);
            cenb   = ($urandom_range(0, 3) == 0);
            wena   = $urandom_range(0, 1) == 1;
            wenb   = $urandom_range(0, 1) == 1;
            oena   = ($urandom_range(0, 7) == 0);
            oenb   = ($urandom_range(0, 7) == 0);
            wmaska = 4'($urandom_range(0, 15));
            wmaskb = 4'($urandom_range(0, 15));
            addra  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(470, 511)) : 9'($urandom_range(0, 15));
            addrb  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(470, 511)) : 9'($urandom_range(0, 15));
            dataa  = $urandom;
            datab  = $urandom;
            tick();
        end
        set_idle();
        tick();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
